// File: rtl/weight_fifo_fill_ctrl.sv
// rtl/weight_fifo_fill_ctrl.sv - fill controller issuing per-lane weight memory reads into lane FIFOs
// Optional feature macro WFILL_LANE_STRIDE_EN: lane i address additionally offset by i*stride.
module weight_fifo_fill_ctrl #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  localparam int LEN_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic                  abort,
  input  logic                  fifo_ready,
  output logic                  busy,
  output logic                  done,
  output logic [FIFO_WIDTH-1:0] w_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] w_mem_rd_addr [0:FIFO_WIDTH-1],
  output logic [FIFO_WIDTH-1:0] fifo_en
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, len_q, len_d;
  logic [LEN_WIDTH-1:0]  issue_cnt, issue_len, clamp_len;
  logic [ADDR_WIDTH-1:0] base_q, base_d, stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] issue_base, issue_stride;
  logic                  issue, last_issue, flush;
  logic                  zero_done_q, zero_done_d, last_q, last_out;
  logic [ADDR_WIDTH-1:0] addr_d [FIFO_WIDTH];
  logic [FIFO_WIDTH-1:0] en_pipe [RD_LATENCY];
  logic [RD_LATENCY-1:0] last_pipe;

  assign clamp_len  = (burst_len > LEN_WIDTH'(FIFO_DEPTH)) ? LEN_WIDTH'(FIFO_DEPTH) : burst_len;
  assign last_issue = issue && (issue_cnt == issue_len - LEN_WIDTH'(1));
  assign last_out   = last_pipe[RD_LATENCY-1];
  assign fifo_en    = en_pipe[RD_LATENCY-1];
  assign busy       = (state_q != IDLE);
  assign done       = zero_done_q | ((state_q == DRAIN) && last_out && !abort);

  // The accepting IDLE cycle already issues read 0 so rd_en rises together with busy.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    stride_d     = stride_q;
    issue        = 1'b0;
    flush        = 1'b0;
    zero_done_d  = 1'b0;
    issue_cnt    = cnt_q;
    issue_len    = len_q;
    issue_base   = base_q;
    issue_stride = stride_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (burst_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            len_d        = clamp_len;
            base_d       = base_addr;
            stride_d     = stride;
            issue_cnt    = '0;
            issue_len    = clamp_len;
            issue_base   = base_addr;
            issue_stride = stride;
            issue        = fifo_ready;
            cnt_d        = fifo_ready ? LEN_WIDTH'(1) : '0;
            state_d      = (fifo_ready && clamp_len == LEN_WIDTH'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (fifo_ready) begin
          issue = 1'b1;
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (cnt_q == len_q - LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (last_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < FIFO_WIDTH; i++) begin
`ifdef WFILL_LANE_STRIDE_EN
      addr_d[i] = issue_base + ADDR_WIDTH'(i) * issue_stride + ADDR_WIDTH'(issue_cnt);
`else
      addr_d[i] = issue_base + ADDR_WIDTH'(issue_cnt);
`endif
    end
  end

`ifndef WFILL_LANE_STRIDE_EN
  logic unused_stride;
  assign unused_stride = ^issue_stride;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      stride_q    <= '0;
      zero_done_q <= 1'b0;
      last_q      <= 1'b0;
      w_mem_rd_en <= '0;
      for (int i = 0; i < FIFO_WIDTH; i++) w_mem_rd_addr[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      stride_q    <= stride_d;
      zero_done_q <= zero_done_d;
      last_q      <= last_issue;
      w_mem_rd_en <= {FIFO_WIDTH{issue}};
      if (issue) begin
        for (int i = 0; i < FIFO_WIDTH; i++) w_mem_rd_addr[i] <= addr_d[i];
      end
    end
  end

  // Write-enable pipeline mirrors memory read latency; abort drops in-flight reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < RD_LATENCY; k++) en_pipe[k] <= '0;
      last_pipe <= '0;
    end else if (flush) begin
      for (int k = 0; k < RD_LATENCY; k++) en_pipe[k] <= '0;
      last_pipe <= '0;
    end else begin
      en_pipe[0]   <= w_mem_rd_en;
      last_pipe[0] <= last_q;
      for (int k = 1; k < RD_LATENCY; k++) begin
        en_pipe[k]   <= en_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
      end
    end
  end

endmodule

// File: tb/tb_weight_fifo_fill_ctrl.sv
// tb/tb_weight_fifo_fill_ctrl.sv - scoreboard bench for weight_fifo_fill_ctrl
// Lane-address expectations follow WFILL_LANE_STRIDE_EN when it is defined for the build.
module tb_weight_fifo_fill_ctrl;
  localparam int FW  = 16;
  localparam int FD  = 16;
  localparam int AW  = 8;
  localparam int RDL = 2;
  localparam int LW  = 5;
`ifdef WFILL_LANE_STRIDE_EN
  localparam bit STRIDE_ON = 1'b1;
`else
  localparam bit STRIDE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          fifo_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = '0;
  logic [LW-1:0] burst_len = '0;
  logic          busy, done;
  logic [FW-1:0] w_mem_rd_en, fifo_en;
  logic [AW-1:0] w_mem_rd_addr [0:FW-1];

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] cur_stride = '0;

  always #5 clk = ~clk;

  weight_fifo_fill_ctrl #(
    .FIFO_WIDTH(FW), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .burst_len(burst_len), .stride(stride), .abort(abort), .fifo_ready(fifo_ready),
    .busy(busy), .done(done), .w_mem_rd_en(w_mem_rd_en),
    .w_mem_rd_addr(w_mem_rd_addr), .fifo_en(fifo_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] lane_addr(input logic [AW-1:0] a, input int lane,
                                              input logic [AW-1:0] s);
    return a + (STRIDE_ON ? AW'(lane) * s : AW'(0));
  endfunction

  task automatic check_cycle(input int c, input logic e_rd, input logic e_fe,
                             input logic e_busy, input logic e_done);
    logic [AW-1:0] a;
    chk($sformatf("rd_en c%0d", c), w_mem_rd_en, {FW{e_rd}});
    chk($sformatf("fifo_en c%0d", c), fifo_en, {FW{e_fe}});
    chk($sformatf("busy c%0d", c), busy, e_busy);
    chk($sformatf("done c%0d", c), done, e_done);
    if (w_mem_rd_en != '0) begin
      chk($sformatf("read_expected c%0d", c), exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        a = exp_q.pop_front();
        for (int i = 0; i < FW; i++)
          chk($sformatf("addr c%0d l%0d", c, i), w_mem_rd_addr[i], lane_addr(a, i, cur_stride));
      end
    end
  endtask

  // ab: cycle in which abort is driven (-1 none); rs: cycle of a start while busy (-1 none)
  task automatic run_fill(input logic [AW-1:0] base, input logic [LW-1:0] blen,
                          input logic [AW-1:0] str, input logic [63:0] stall,
                          input int ab, input int rs);
    logic [63:0] e_rd, e_fe, e_busy, e_done;
    int len, issued, last, fin;
    e_rd = '0; e_fe = '0; e_busy = '0; e_done = '0;
    len = (int'(blen) > FD) ? FD : int'(blen);
    issued = 0; last = 0;
    cur_stride = str;
    for (int c = 0; c < 60 && issued < len; c++) begin
      if (ab >= 0 && c >= ab) break;
      if (!stall[c]) begin
        e_rd[c+1] = 1'b1;
        exp_q.push_back(base + AW'(issued));
        issued++;
        last = c + 1;
      end
    end
    if (ab >= 0) begin
      fin = ab + 2;
      for (int c = 1; c <= ab; c++) e_busy[c] = 1'b1;
    end else if (len == 0) begin
      fin = 2;
      e_done[1] = 1'b1;
    end else begin
      fin = last + RDL + 1;
      e_done[last+RDL] = 1'b1;
      for (int c = 1; c <= last + RDL; c++) e_busy[c] = 1'b1;
    end
    for (int c = RDL; c < 64; c++) e_fe[c] = e_rd[c-RDL] && !(ab >= 0 && c > ab);
    for (int c = 0; c < fin; c++) begin
      start      = (c == 0) || (c == rs);
      abort      = (c == ab);
      fifo_ready = !stall[c];
      base_addr  = (c == 0) ? base : ~base;
      burst_len  = (c == 0) ? blen : LW'(3);
      stride     = (c == 0) ? str : ~str;
      @(posedge clk);
      @(negedge clk);
      check_cycle(c + 1, e_rd[c+1], e_fe[c+1], e_busy[c+1], e_done[c+1]);
    end
    start = 1'b0;
    abort = 1'b0;
    fifo_ready = 1'b1;
    chk("all_reads_seen", exp_q.size(), 0);
  endtask

  initial begin
    rstn = 1'b0;
    fifo_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rd_en", w_mem_rd_en, 0);
    chk("rst fifo_en", fifo_en, 0);
    chk("rst addr0", w_mem_rd_addr[0], 0);
    chk("rst addr15", w_mem_rd_addr[FW-1], 0);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle busy", busy, 0);

    run_fill(8'h10, 5'd4,  8'h10, 64'h0, -1, 2);
    run_fill(8'h10, 5'd6,  8'h10, 64'hC, -1, -1);
    run_fill(8'hFE, 5'd4,  8'h01, 64'h0, -1, -1);
    run_fill(8'h50, 5'd3,  8'h20, 64'h3, -1, -1);
    run_fill(8'h20, 5'd8,  8'h10, 64'h0, 3, -1);
    run_fill(8'h40, 5'd8,  8'h10, 64'h0, -1, -1);
    run_fill(8'h70, 5'd0,  8'h10, 64'h0, -1, -1);
    run_fill(8'h00, 5'd31, 8'h04, 64'h0, -1, -1);
    run_fill(8'h30, 5'd5,  8'h10, 64'h0, 0, -1);
    run_fill(8'h00, 5'd2,  8'h10, 64'h0, -1, -1);
    run_fill(8'hA0, 5'd1,  8'h10, 64'h0, -1, -1);

    start = 1'b1; base_addr = 8'h60; burst_len = 5'd8; stride = 8'h10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset rd_en", w_mem_rd_en, 16'hFFFF);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst busy", busy, 0);
    chk("mid_rst done", done, 0);
    chk("mid_rst rd_en", w_mem_rd_en, 0);
    chk("mid_rst fifo_en", fifo_en, 0);
    for (int i = 0; i < FW; i++) chk($sformatf("mid_rst addr l%0d", i), w_mem_rd_addr[i], 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post_rst busy %0d", c), busy, 0);
      chk($sformatf("post_rst done %0d", c), done, 0);
      chk($sformatf("post_rst fifo_en %0d", c), fifo_en, 0);
    end
    run_fill(8'h60, 5'd8, 8'h08, 64'h0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/weight_fifo_fill_ctrl.md
WEIGHT_FIFO_FILL_CTRL -- requirements
Module: weight_fifo_fill_ctrl

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, number of weight FIFO lanes / memory read ports.
REQ-002 Parameter FIFO_DEPTH, default 16, maximum entries written per lane per fill.
REQ-003 Parameter ADDR_WIDTH, default 8, weight memory address width.
REQ-004 Parameter RD_LATENCY, default 2, weight memory read latency in cycles (>=1).
REQ-005 Localparam LEN_WIDTH = $clog2(FIFO_DEPTH)+1.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 start  input  1  fill request pulse; sampled only in IDLE.
REQ-009 base_addr  input  ADDR_WIDTH  first memory address of the fill.
REQ-010 burst_len  input  LEN_WIDTH  entries to fetch per lane.
REQ-011 stride  input  ADDR_WIDTH  per-lane address offset; used only when WFILL_LANE_STRIDE_EN is defined.
REQ-012 abort  input  1  cancel the current fill.
REQ-013 fifo_ready  input  1  downstream FIFOs can accept one more entry; low stalls issue.
REQ-014 busy  output  1  fill in progress.
REQ-015 done  output  1  one-cycle pulse on final write of a fill.
REQ-016 w_mem_rd_en  output  FIFO_WIDTH  per-lane memory read enable, registered.
REQ-017 w_mem_rd_addr  output  [0:FIFO_WIDTH-1] x ADDR_WIDTH  per-lane read address, registered.
REQ-018 fifo_en  output  FIFO_WIDTH  per-lane FIFO write enable, aligned to memory read data.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, DRAIN.
REQ-020 IDLE: start=1 and abort=0 SHALL latch base_addr, stride and len=min(burst_len, FIFO_DEPTH), clear issue counter cnt, and go to ISSUE.
REQ-021 IDLE: start with burst_len=0 SHALL stay in IDLE and pulse done the next cycle, with no reads issued.
REQ-022 start while busy SHALL be ignored; latched values SHALL NOT change.
REQ-023 ISSUE: each cycle with fifo_ready=1 SHALL register w_mem_rd_en all-ones and set lane i address to base+cnt (+i*stride, see REQ-036), then increment cnt.
REQ-024 ISSUE with fifo_ready=0 SHALL register w_mem_rd_en=0, hold cnt and hold the address outputs.
REQ-025 Address sums SHALL wrap modulo 2^ADDR_WIDTH.
REQ-026 Issuing read cnt=len-1 SHALL move the FSM to DRAIN.
REQ-027 fifo_en SHALL equal w_mem_rd_en delayed by RD_LATENCY cycles through a shift pipeline that is independent of fifo_ready.
REQ-028 DRAIN SHALL wait until the last issued read reaches fifo_en, pulse done in that same cycle, and return to IDLE on the next cycle.
REQ-029 busy SHALL be 1 from the cycle after start is accepted through the done cycle inclusive.
REQ-030 abort in ISSUE or DRAIN SHALL return the FSM to IDLE next cycle, zero w_mem_rd_en, flush the fifo_en pipeline, and SHALL NOT pulse done.
REQ-031 abort and start in the same IDLE cycle: abort wins and start is ignored.
REQ-032 A start accepted in the cycle after done SHALL begin a new fill without a gap cycle.

Reset
REQ-033 rstn=0 SHALL asynchronously force: FSM IDLE; cnt, len and latched base/stride 0; busy, done, w_mem_rd_en and fifo_en 0; all w_mem_rd_addr 0; fifo_en pipeline cleared.
REQ-034 Reset mid-fill SHALL discard the fill with no done pulse; after release the block SHALL accept start normally.

Configuration
REQ-035 Macro WFILL_LANE_STRIDE_EN SHALL select the lane-address mode.
REQ-036 With the macro defined: lane i address = base+i*stride+cnt, modulo 2^ADDR_WIDTH.
REQ-037 Without the macro: every lane address = base+cnt, and the stride port is ignored.

Verification
REQ-038 base=0x10, len=4, fifo_ready=1, RD_LATENCY=2 -> rd_en cycles 1-4, lane addresses 0x10-0x13, fifo_en cycles 3-6, done cycle 6, busy cycles 1-6.
REQ-039 len=6, fifo_ready low for cycles 2-3 -> addresses 0x10-0x15 each issued exactly once, no duplicates, done delayed 2 cycles versus an unstalled fill.
REQ-040 base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-041 abort at cycle 3 of an 8-entry fill -> rd_en=0 and fifo_en=0 from cycle 4, no done, busy=0 at cycle 4; a subsequent start runs a full fill.
REQ-042 burst_len=0 -> no rd_en and done pulse 1 cycle later; burst_len=31 with FIFO_DEPTH=16 -> exactly 16 reads.
REQ-043 WFILL_LANE_STRIDE_EN defined, base=0x00, stride=0x10, len=2 -> lane 3 addresses 0x30, 0x31; rstn pulsed mid-fill -> all outputs 0 immediately.
